// File: rtl/intf_nested_responder.sv
// intf_nested_responder: register-file responder whose request capture lives in a nested interface.
// Optional INTF_RESP_BYPASS_EN drops the EXEC state so the operation runs at the accept edge.
interface req_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
endinterface

interface cap_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3) (
    input logic              i_clk,
    input logic              rst,
    input logic              take,
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
);
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    always_ff @(posedge i_clk) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (take) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
        end
    end
endinterface

interface chan_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3) (input logic i_clk);
    logic rst;
    logic ready;
    logic take;
    req_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_req();
    cap_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap (
        .i_clk(i_clk), .rst(rst), .take(take),
        .we(u_req.we), .addr(u_req.addr), .wdata(u_req.wdata)
    );
    assign take = u_req.valid & ready;
endinterface

module intf_nested_responder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);
`ifdef INTF_RESP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              accept, do_op, op_we, in_range;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    chan_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_chan (.i_clk(i_clk));

    assign u_chan.rst         = i_rst;
    assign u_chan.ready       = o_req_ready;
    assign u_chan.u_req.valid = i_req_valid;
    assign u_chan.u_req.we    = i_req_we;
    assign u_chan.u_req.addr  = i_req_addr;
    assign u_chan.u_req.wdata = i_req_wdata;

    assign o_req_ready = (state == IDLE) && !i_rst;
    assign o_rsp_valid = (state == RESP);
    assign o_busy      = (state != IDLE);
    assign accept      = u_chan.take;

    // Bypass operates on the live request; otherwise on the fields captured last edge.
    always_comb begin
        do_op    = BYP ? accept : (state == EXEC);
        op_we    = BYP ? i_req_we : u_chan.u_cap.cap_we;
        op_addr  = BYP ? i_req_addr : u_chan.u_cap.cap_addr;
        op_wdata = BYP ? i_req_wdata : u_chan.u_cap.cap_wdata;
        in_range = {1'b0, op_addr} < DEPTH_L;
        state_n  = (state == IDLE) ? (accept ? (BYP ? RESP : EXEC) : IDLE) :
                   (state == EXEC) ? RESP :
                   (i_rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            if (do_op) begin
                if (in_range && op_we) regs[op_addr] <= op_wdata;
                o_rsp_rdata <= (in_range && !op_we) ? regs[op_addr] : '0;
                o_rsp_err   <= !in_range;
            end else if (state == RESP && i_rsp_ready) begin
                o_rsp_rdata <= '0;
                o_rsp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_intf_nested_responder.sv
// tb_intf_nested_responder: directed checks of the nested-interface responder.
// Honors INTF_RESP_BYPASS_EN for the expected latency.
module tb_intf_nested_responder;
`ifdef INTF_RESP_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
    logic [2:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;
    int         nvec = 0, nerr = 0;

    intf_nested_responder dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 1;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, LAT);
    endtask

    task automatic xact(input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("latency");
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
    endtask

    initial begin
        int k, last;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 8'h77; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        for (int a = 0; a < 6; a++) xact(1'b0, 3'(a), 8'h00, 8'h00, 1'b0);

        xact(1'b1, 3'd2, 8'hA5, 8'h00, 1'b0);
        xact(1'b0, 3'd2, 8'h00, 8'hA5, 1'b0);

        xact(1'b1, 3'd5, 8'h5A, 8'h00, 1'b0);
        xact(1'b0, 3'd7, 8'h00, 8'h00, 1'b1);
        xact(1'b1, 3'd6, 8'hFF, 8'h00, 1'b1);
        xact(1'b0, 3'd5, 8'h00, 8'h5A, 1'b0);

        // Backpressure: a second request is held while the first response waits.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 3'd5;
        wait_rsp("bp_latency");
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 8'hA5);
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        chk("bp_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_hs_valid", rsp_valid, 0);
        chk("bp_after_hs_rdata", rsp_rdata, 0);
        chk("bp_after_hs_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("bp2_latency");
        chk("bp2_rdata", rsp_rdata, 8'h5A);

        // Reset while the write response is pending.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'h3C; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("rr_latency");
        rst = 1'b1;
        @(negedge clk);
        chk("rr_rsp_valid", rsp_valid, 0);
        chk("rr_busy", busy, 0);
        chk("rr_req_ready", req_ready, 0);
        rst = 1'b0;
        xact(1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
        xact(1'b0, 3'd2, 8'h00, 8'h00, 1'b0);

        // Streaming writes with valid and ready held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd0; req_wdata = 8'h10; rsp_ready = 1'b1;
        k = 0; last = -1;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            chk("stream_busy", busy, !req_ready);
            if (req_ready) begin
                if (k > 0) chk("stream_gap", cyc - last, LAT + 1);
                last = cyc;
                k++;
                @(posedge clk);
                #1;
                req_addr = 3'(k); req_wdata = 8'(8'h10 + 8'h11 * k);
                if (k == 4) req_valid = 1'b0;
            end
        end
        chk("stream_count", k, 4);
        repeat (LAT) @(negedge clk);
        xact(1'b0, 3'd0, 8'h00, 8'h10, 1'b0);
        xact(1'b0, 3'd1, 8'h00, 8'h21, 1'b0);
        xact(1'b0, 3'd2, 8'h00, 8'h32, 1'b0);
        xact(1'b0, 3'd3, 8'h00, 8'h43, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
